// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and line filter.
// Holds the transmitter state encoding, error codes and frame length.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        XFER,
        WAIT_IDLE,
        FIN,
        FAIL
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NOACK   = 2'b10;

    localparam int unsigned FRAME_FALLS = 11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser for one PS/2 line, with an optional glitch filter
// enabled by PS2_TX_GLITCH_FILTER_EN (output moves after FILTER_LEN equal samples).
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic q
);

    logic [1:0] sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync <= 2'b11;
        else          sync <= {sync[0], pin};
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [CW-1:0] cnt;
    logic          filt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            filt <= 1'b1;
        end else if (sync[1] == filt) begin
            cnt <= '0;
        end else if (cnt == CW'(FILTER_LEN - 1)) begin
            filt <= sync[1];
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign q = filt;
`else
    localparam int unsigned unused_filter_len = FILTER_LEN;

    assign q = sync[1];
`endif

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain clock/data.
// Define PS2_TX_GLITCH_FILTER_EN to filter both input lines against glitches.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 1250,
    parameter int unsigned TIMEOUT_CYCLES = 187500,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    state_t           state_q, state_d;
    logic [INH_W-1:0] inh_q;
    logic [TO_W-1:0]  to_q;
    logic [3:0]       bit_q;
    logic [8:0]       frame_q;
    logic             doe_q;
    logic [1:0]       err_q;
    logic             clk_prev;
    logic             clk_s, data_s;
    logic             fall, timeout;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (ps2_clk_in),
        .q       (clk_s)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (ps2_data_in),
        .q       (data_s)
    );

    assign fall     = clk_prev & ~clk_s;
    assign timeout  = (to_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign err_code = err_q;

    always_comb begin
        state_d     = state_q;
        done        = 1'b0;
        error       = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tx_valid) state_d = INHIBIT;
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) state_d = REQ;
            end
            REQ: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                state_d     = XFER;
            end
            XFER: begin
                ps2_data_oe = doe_q;
                // timeout takes priority over a coincident final fall
                if (timeout)
                    state_d = FAIL;
                else if (fall && bit_q == 4'(FRAME_FALLS - 1))
                    state_d = data_s ? FAIL : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (timeout)              state_d = FAIL;
                else if (clk_s && data_s) state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            FAIL: begin
                error   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            inh_q    <= '0;
            to_q     <= '0;
            bit_q    <= '0;
            frame_q  <= '0;
            doe_q    <= 1'b0;
            err_q    <= ERR_NONE;
            clk_prev <= 1'b1;
        end else begin
            state_q  <= state_d;
            clk_prev <= clk_s;
            unique case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        frame_q <= {odd_parity(tx_data), tx_data};
                        err_q   <= ERR_NONE;
                        inh_q   <= '0;
                    end
                end
                INHIBIT: inh_q <= inh_q + 1'b1;
                REQ: begin
                    bit_q <= '0;
                    to_q  <= '0;
                    doe_q <= 1'b1;
                end
                XFER: begin
                    if (timeout) begin
                        err_q <= ERR_TIMEOUT;
                    end else begin
                        to_q <= to_q + 1'b1;
                        if (fall) begin
                            bit_q <= bit_q + 4'd1;
                            // falls 1..9 present data then parity; later ones release
                            if (bit_q < 4'd9) doe_q <= ~frame_q[bit_q];
                            else              doe_q <= 1'b0;
                            if (bit_q == 4'(FRAME_FALLS - 1) && data_s)
                                err_q <= ERR_NOACK;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (timeout) err_q <= ERR_TIMEOUT;
                    else         to_q  <= to_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device model.
// Define PS2_TX_GLITCH_FILTER_EN to exercise the filtered build.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH = 1250;
    localparam int TO  = 3000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, error;
    logic [1:0] err_code;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;

    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic glitch = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int n_done = 0;
    int n_fail = 0;
    int inh_len = 0;

    always #40 clk = ~clk;

    assign ps2_clk_in  = dev_clk & ~glitch & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done)  n_done++;
        if (error) n_fail++;
        if (done || error) check("done_error_excl", {31'd0, done & error}, 0);
    end

    // Wire-level frame: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        int ones = 0;
        logic [10:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = ((b >> i) & 8'd1) != 0;
            ones += int'((b >> i) & 8'd1);
        end
        f[9]  = (ones % 2) == 0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [7:0] b);
        int w = 0;
        @(negedge clk);
        while (!tx_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_send", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        check("busy_after_accept", busy, 1);
        check("ready_after_accept", tx_ready, 0);
    endtask

    task automatic device_frame(input int half, input int nfalls,
                                input bit ack, input bit glitch_en,
                                output logic [10:0] bits);
        int w = 0;
        bits = '1;
        inh_len = 0;
        while (ps2_clk_oe && w < INH + 100) begin
            inh_len++;
            @(negedge clk);
            w++;
        end
        bits[0] = ps2_data_in;
        for (int i = 1; i <= nfalls; i++) begin
            if (i == 11 && ack) begin
                repeat (half - 10) @(negedge clk);
                dev_data = 1'b0;
                repeat (10) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (half) @(negedge clk);
            if (i <= 10) bits[i] = ps2_data_in;
            dev_clk = 1'b1;
            if (i == 11) dev_data = 1'b1;
            if (glitch_en && i == 5) begin
                repeat (half / 2) @(negedge clk);
                glitch = 1'b1;
                repeat (2) @(negedge clk);
                glitch = 1'b0;
            end
        end
        if (nfalls > 0) repeat (half) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] b, input int half, input bit ack,
                             input bit glitch_en, input bit exp_ok, input string tag);
        logic [10:0] bits;
        int w = 0;
        n_done = 0;
        n_fail = 0;
        send(b);
        device_frame(half, 11, ack, glitch_en, bits);
        while (n_done + n_fail == 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_inhibit"}, inh_len, INH + 1);
        if (exp_ok) begin
            check({tag, "_bits"}, {21'd0, bits}, {21'd0, frame_bits(b)});
            check({tag, "_done"}, n_done, 1);
            check({tag, "_noerr"}, n_fail, 0);
            check({tag, "_errcode"}, err_code, 2'b00);
        end else begin
            check({tag, "_nodone"}, n_done, 0);
            check({tag, "_err"}, n_fail, 1);
            check({tag, "_errcode"}, err_code, 2'b10);
        end
        check({tag, "_ready"}, tx_ready, 1);
        check({tag, "_idle_clk"}, ps2_clk_oe, 0);
        check({tag, "_idle_data"}, ps2_data_oe, 0);
    endtask

    initial begin
        logic [10:0] bits;
        int cnt;

        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_errcode", err_code, 2'b00);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // device clocks at ~12 kHz: half period 520 cycles is too slow for budget,
        // so the bench uses a faster device; protocol timing is relative anyway
        run_frame(8'hED, 45, 1, 0, 1, "ed");
        run_frame(8'hF4, 40, 1, 0, 1, "f4");
        run_frame(8'hFF, 40, 1, 0, 1, "ff_b2b");

        // device silent after request-to-send
        n_done = 0;
        n_fail = 0;
        send(8'h55);
        device_frame(40, 0, 0, 0, bits);
        check("to_start_bit", bits[0], 0);
        cnt = 0;
        while (!error && cnt < TO + 50) begin
            @(negedge clk);
            cnt++;
        end
        check("to_cycles", cnt, TO);
        check("to_errcode", err_code, 2'b01);
        check("to_clk_oe", ps2_clk_oe, 0);
        check("to_data_oe", ps2_data_oe, 0);
        repeat (3) @(negedge clk);
        check("to_nodone", n_done, 0);
        check("to_ready", tx_ready, 1);
        check("to_errcode_held", err_code, 2'b01);

        run_frame(8'h3C, 40, 0, 0, 0, "noack");

        // asynchronous reset mid-frame, with data being driven low
        send(8'h00);
        device_frame(40, 5, 0, 0, bits);
        check("arst_pre_data_oe", ps2_data_oe, 1);
        #5 reset_n = 1'b0;
        #1;
        check("arst_data_oe", ps2_data_oe, 0);
        check("arst_clk_oe", ps2_clk_oe, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", tx_ready, 1);
        #10 reset_n = 1'b1;
        run_frame(8'h6B, 40, 1, 0, 1, "after_rst");

`ifdef PS2_TX_GLITCH_FILTER_EN
        run_frame(8'hA5, 40, 1, 1, 1, "glitch_filt");
`else
        run_frame(8'hA5, 40, 1, 1, 0, "glitch_nofilt");
`endif

        for (int k = 0; k < 6; k++) begin
            run_frame(8'($urandom), int'($urandom_range(30, 60)), 1, 0, 1, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
